// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
// Two-entry valid/ready pipeline stage with a registered in_ready. The skid
// register absorbs the one payload that can arrive in the cycle after
// downstream stalls. Because of that, in_ready never depends combinationally
// on out_ready.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (priority over flush)
//   flush      synchronous squash of all held entries (priority over transfers)
//   in_valid   upstream presents in_data
//   in_ready   registered; block will accept a payload this cycle
//   in_data    upstream payload, WIDTH bits
//   out_valid  a payload is presented on out_data
//   out_ready  downstream accepts out_data this cycle
//   out_data   head payload, driven straight from the main register
//   occupancy  number of held entries (0, 1 or 2)
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;

    logic             w_it;
    logic             w_ot;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;

    assign w_it = in_valid && r_in_ready;
    assign w_ot = out_valid && out_ready;

    // Next-state and register-load selection. On flush, the state goes to
    // EMPTY and no load happens. The stale contents of main and skid are
    // harmless because out_valid is 0 in EMPTY.
    always_comb begin
        w_next_state     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_it) begin
                        w_next_state   = ST_BUSY;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_it && !w_ot) begin
                        w_next_state   = ST_FULL;
                        w_skid_from_in = 1'b1;
                    end else if (w_ot && !w_it) begin
                        w_next_state = ST_EMPTY;
                    end else if (w_it && w_ot) begin
                        w_main_from_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is 0 here, so only the output side can move.
                    if (w_ot) begin
                        w_next_state     = ST_BUSY;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered ready: look ahead at whether the next state has room.
            r_in_ready <= (w_next_state != ST_FULL);
            if (w_main_from_in) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= in_data;
            end
        end
    end

    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_valid = (r_state == ST_BUSY) || (r_state == ST_FULL);
    assign in_ready  = r_in_ready;
    assign out_data  = r_main;

endmodule
